bullet_slot_scheduler: RTL
==========================

# bullet_slot_scheduler

Allocates, launches, advances and retires the three Bullet Bill slots for the game state logic. Converts Nunchuk fire presses into launches of colored bullets and assigns each launch to the lowest free slot. Paces launches with a cooldown and moves in-flight bullets on each movement tick. Retires a bullet on a collision report from the Ddaver logic or when it leaves the grid.

## Interface
Parameters:
- NUM_SLOTS, 3: bullet slots managed; fixed at 3 for the packed port widths below.
- SPAWN_X, 1: x column assigned at launch.
- MAX_X, 15: last on-grid column; a bullet here retires on its next move_tick.
- COOLDOWN, 4: move_ticks after a launch during which new fire presses are dropped.

Ports:
- vga_clock  in  1  sole clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- move_tick  in  1  one-cycle pulse that advances every in-flight bullet one column.
- z  in  1  Nunchuk Z button, level.
- c  in  1  Nunchuk C button, level.
- shooter_y  in  4  current Blockieee row; copied into a slot's y at launch.
- hit  in  3  per-slot collision pulse (bit i = slot i); retires the slot.
- bb_state  out  6  2 bits per slot, slot i at [2i+1:2i]: 0 BBDNE (empty), 1 EBLUE, 2 ERED, 3 EGREEN.
- bb_x  out  12  4-bit x per slot, slot i at [4i+3:4i].
- bb_y  out  12  4-bit y per slot, slot i at [4i+3:4i].
- fire_ack  out  1  one-cycle pulse: a launch occurred.
- fire_drop  out  1  one-cycle pulse: a fire edge was rejected.

## Operation
- Fire edge: fire_edge = (z|c) & ~prev_fire; prev_fire is a register of (z|c). Only edges launch bullets; holding a button does not auto-fire.
- Color at the edge cycle: z&~c gives EBLUE; c&~z gives ERED; z&c gives EGREEN.
- Launch condition: fire_edge, cooldown counter == 0, and at least one slot in BBDNE.
  - Slot selection uses the registered bb_state.
  - The lowest-index empty slot is chosen.
  - The chosen slot gets state = color, x = SPAWN_X, y = shooter_y, and the cooldown counter is loaded with COOLDOWN.
- Drop: any fire_edge that does not launch pulses fire_drop. No state changes.
- Per-slot FSM: BBDNE goes to a color state on launch. A color state returns to BBDNE on hit[i], or on move_tick while x == MAX_X. Otherwise, on move_tick, x increments by 1. y is constant in flight.
- Retirement zeroes the slot's x and y.
- Cooldown: decrements by 1 on each move_tick while nonzero and saturates at 0. The load on launch takes priority over a decrement in the same cycle.
- Arithmetic: x is 4-bit. The x == MAX_X retire check precedes the increment, so x never wraps.
- Priorities within one cycle:
  - For a given slot, hit beats move_tick.
  - A slot freed by hit this cycle is not allocatable until the next cycle.
  - A newly launched slot is not advanced by a coincident move_tick.
  - hit[i] on an empty slot is ignored.
- Reset:
  - All bb_state = BBDNE; all bb_x and bb_y = 0.
  - fire_ack = fire_drop = 0; cooldown = 0.
  - prev_fire = 1, so a button held through reset does not fire.
  - Reset asserted mid-flight clears every slot on the next edge.

## Timing
- A fire edge sampled at edge N appears in the slot outputs after edge N, i.e. visible in cycle N+1, together with a one-cycle fire_ack (or fire_drop).
- move_tick and hit take effect at the edge that samples them, so they are visible one cycle later.
- All outputs are registered; no combinational input-to-output paths.
- Throughput: at most one launch per COOLDOWN move_ticks, plus one.

## Test plan
- Reset with z held, then release rst: no fire_ack and all slots BBDNE. Then release and press z with shooter_y=7 -> slot 0 = EBLUE, x=1, y=7, fire_ack one cycle later.
- Press z, c, then z+c, each separated by 4 move_ticks -> slots 0/1/2 = EBLUE/ERED/EGREEN. A fourth press after 4 more ticks -> fire_drop, no change.
- Press c, then press again after 2 move_ticks -> fire_drop. After 2 more ticks a press -> launch into slot 1.
- Slot 0 in flight, 14 move_ticks -> x reaches 15. Next move_tick -> slot 0 = BBDNE, x=0, y=0.
- Slots 0 and 1 full; hit=3'b001 with move_tick and a fire edge in the same cycle -> slot 0 cleared, slot 1 advanced, launch goes to slot 2. The next press (after cooldown) launches into slot 0.
- Assert rst with 3 slots in flight -> all outputs 0 at the next edge; hit pulses on empty slots cause no change.

Source files
------------

// File: rtl/bullet_slot_scheduler.sv
// bullet_slot_scheduler: launches fire presses into the lowest free slot, advances bullets on move_tick and retires them on hit or off-grid.
module bullet_slot_scheduler #(
  parameter int NUM_SLOTS = 3,
  parameter int SPAWN_X   = 1,
  parameter int MAX_X     = 15,
  parameter int COOLDOWN  = 4
) (
  input  logic                   vga_clock,
  input  logic                   rst,
  input  logic                   move_tick,
  input  logic                   z,
  input  logic                   c,
  input  logic [3:0]             shooter_y,
  input  logic [NUM_SLOTS-1:0]   hit,
  output logic [2*NUM_SLOTS-1:0] bb_state,
  output logic [4*NUM_SLOTS-1:0] bb_x,
  output logic [4*NUM_SLOTS-1:0] bb_y,
  output logic                   fire_ack,
  output logic                   fire_drop
);
  localparam int CW = $clog2(COOLDOWN + 1);
  localparam logic [1:0] BBDNE = 2'd0;
  logic [1:0]    state_q [NUM_SLOTS];
  logic [1:0]    state_d [NUM_SLOTS];
  logic [3:0]    x_q [NUM_SLOTS];
  logic [3:0]    x_d [NUM_SLOTS];
  logic [3:0]    y_q [NUM_SLOTS];
  logic [3:0]    y_d [NUM_SLOTS];
  logic [CW-1:0] cool_q, cool_d;
  logic          prev_fire_q, prev_fire_d;
  logic          ack_q, ack_d, drop_q, drop_d;
  logic          fire_edge, any_free, launch;
  logic [1:0]    sel;
  always_comb begin
    fire_edge = (z | c) & ~prev_fire_q;
    sel = '0;
    any_free = 1'b0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--)
      if (state_q[i] == BBDNE) begin
        sel = 2'(i);
        any_free = 1'b1;
      end
    launch = fire_edge && cool_q == '0 && any_free;
    cool_d = launch ? CW'(COOLDOWN) : (move_tick && cool_q != '0) ? cool_q - 1'b1 : cool_q;
    ack_d = launch;
    drop_d = fire_edge & ~launch;
    prev_fire_d = z | c;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      state_d[i] = state_q[i];
      x_d[i] = x_q[i];
      y_d[i] = y_q[i];
      if (state_q[i] != BBDNE) begin
        if (hit[i] || (move_tick && x_q[i] == 4'(MAX_X))) begin
          state_d[i] = BBDNE;
          x_d[i] = '0;
          y_d[i] = '0;
        end else if (move_tick) x_d[i] = x_q[i] + 4'd1;
      end else if (launch && sel == 2'(i)) begin
        // {c,z} maps directly onto EBLUE/ERED/EGREEN
        state_d[i] = {c, z};
        x_d[i] = 4'(SPAWN_X);
        y_d[i] = shooter_y;
      end
    end
  end
  always_ff @(posedge vga_clock) begin
    if (rst) begin
      state_q <= '{default: '0};
      x_q <= '{default: '0};
      y_q <= '{default: '0};
      cool_q <= '0;
      prev_fire_q <= 1'b1;
      ack_q <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q <= x_d;
      y_q <= y_d;
      cool_q <= cool_d;
      prev_fire_q <= prev_fire_d;
      ack_q <= ack_d;
      drop_q <= drop_d;
    end
  end
  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_out
    assign bb_state[2*g +: 2] = state_q[g];
    assign bb_x[4*g +: 4] = x_q[g];
    assign bb_y[4*g +: 4] = y_q[g];
  end
  assign fire_ack = ack_q;
  assign fire_drop = drop_q;
endmodule
